// File: rtl/text_pkg.sv
// Shared definitions for the text overlay feeders: character type, ASCII
// constants and the decimal converter state encoding.
package text_pkg;

  typedef logic [7:0] char_t;

  localparam char_t ASCII_SPACE = 8'h20;
  localparam char_t ASCII_ZERO  = 8'h30;
  localparam char_t ASCII_OVF   = 8'h2A;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FORMAT
  } dec_state_t;

  // 10**n as a 64-bit constant; large enough for ten decimal digits.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_dec_text_bcd_add3.sv
// Double-dabble correction cell: one BCD digit, plus 3 when it is 5 or more.
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_dec_text.sv
// Sequential binary-to-ASCII-decimal converter feeding the text overlay.
// One bit per clock, then a single formatting cycle into a held output string.
module bin_to_dec_text
  import text_pkg::*;
#(
  parameter int VALUE_WIDTH = 16,
  parameter int NUM_DIGITS  = 5,
  parameter int LEAD_BLANK  = 1
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic [VALUE_WIDTH-1:0]       i_value,
  output logic [NUM_DIGITS-1:0][7:0]   o_characters,
  output logic                         o_busy,
  output logic                         o_valid,
  output logic                         o_overflow
);

  localparam int          BCD_W = 4 * NUM_DIGITS;
  localparam int          CNT_W = $clog2(VALUE_WIDTH + 1);
  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

  dec_state_t                 state_q, state_d;
  logic [VALUE_WIDTH-1:0]     bin_q, bin_d;
  logic [BCD_W-1:0]           bcd_q, bcd_d;
  logic [BCD_W-1:0]           bcd_adj;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       ovf_pend_q, ovf_pend_d;
  logic [NUM_DIGITS-1:0][7:0] chars_q, chars_d;
  logic [NUM_DIGITS-1:0][7:0] fmt_chars;
  logic                       ovf_q, ovf_d;
  logic                       valid_q, valid_d;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (bcd_q[4*g +: 4]),
      .o_digit (bcd_adj[4*g +: 4])
    );
  end

  // Walk from the most significant digit down; zeros stay blank until the
  // first nonzero digit, and the units digit always prints.
  always_comb begin
    logic       seen;
    logic [3:0] digit;
    seen      = 1'b0;
    digit     = 4'd0;
    fmt_chars = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      digit = bcd_q[4*i +: 4];
      if (digit != 4'd0) begin
        seen = 1'b1;
      end
      if ((LEAD_BLANK != 0) && !seen && (i != 0)) begin
        fmt_chars[i] = ASCII_SPACE;
      end else begin
        fmt_chars[i] = ASCII_ZERO + {4'd0, digit};
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    chars_d    = chars_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          bin_d      = i_value;
          bcd_d      = '0;
          ovf_pend_d = (64'(i_value) >= LIMIT);
          cnt_d      = CNT_W'(VALUE_WIDTH);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[VALUE_WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FORMAT;
        end
      end
      FORMAT: begin
        chars_d = ovf_pend_q ? {NUM_DIGITS{ASCII_OVF}} : fmt_chars;
        ovf_d   = ovf_pend_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      chars_q    <= {NUM_DIGITS{ASCII_SPACE}};
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      chars_q    <= chars_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign o_characters = chars_q;
  assign o_busy       = (state_q != IDLE);
  assign o_valid      = valid_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_bin_to_dec_text.sv
// Bench for bin_to_dec_text: default, unblanked and 3-digit instances share
// one stimulus stream and are compared against fixed vectors and a model.
module tb_bin_to_dec_text;

  logic            clk;
  logic            iReset;
  logic            iStart;
  logic [15:0]     iValue;
  logic [4:0][7:0] chars5, charsNb;
  logic [2:0][7:0] chars3;
  logic            busy5, valid5, ovf5;
  logic            busyNb, validNb, ovfNb;
  logic            busy3, valid3, ovf3;

  int checks = 0;
  int errors = 0;

  bin_to_dec_text dut (
    .i_clk(clk), .i_reset(iReset), .i_start(iStart), .i_value(iValue),
    .o_characters(chars5), .o_busy(busy5), .o_valid(valid5), .o_overflow(ovf5)
  );

  bin_to_dec_text #(.VALUE_WIDTH(16), .NUM_DIGITS(5), .LEAD_BLANK(0)) dutNb (
    .i_clk(clk), .i_reset(iReset), .i_start(iStart), .i_value(iValue),
    .o_characters(charsNb), .o_busy(busyNb), .o_valid(validNb), .o_overflow(ovfNb)
  );

  bin_to_dec_text #(.VALUE_WIDTH(16), .NUM_DIGITS(3), .LEAD_BLANK(1)) dut3 (
    .i_clk(clk), .i_reset(iReset), .i_start(iStart), .i_value(iValue),
    .o_characters(chars3), .o_busy(busy3), .o_valid(valid3), .o_overflow(ovf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic [39:0] exp5;
    logic [39:0] expNb;
    logic [23:0] exp3;
    logic        ovf3;
  } vec_t;

  vec_t vecs[8];

  // Right-aligned decimal text of v in nd characters, from plain arithmetic.
  function automatic logic [79:0] modelChars(input int unsigned v, input int nd, input bit blank);
    logic [79:0]     r;
    longint unsigned p;
    longint unsigned lim;
    r   = '0;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      if (longint'(v) >= lim)
        r[8*i +: 8] = 8'h2A;
      else if (blank && i > 0 && longint'(v) < p)
        r[8*i +: 8] = 8'h20;
      else
        r[8*i +: 8] = 8'h30 + 8'((longint'(v) / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issues a one-cycle start and returns at the negedge where valid is seen.
  // lat counts negedges after the accept edge; the FORMAT update lands at 18.
  task automatic applyStimulus(input logic [15:0] v, input int interfereAt,
                               input logic [15:0] iv, output int lat, output int busyCyc);
    @(negedge clk);
    iStart = 1'b1;
    iValue = v;
    @(negedge clk);
    iStart  = 1'b0;
    lat     = 0;
    busyCyc = 0;
    for (int k = 1; k <= 40; k++) begin
      if (valid5) begin
        lat = k;
        break;
      end
      if (k == interfereAt) begin
        iStart = 1'b1;
        iValue = iv;
      end else if (k == interfereAt + 1) begin
        iStart = 1'b0;
      end
      if (busy5) busyCyc++;
      @(negedge clk);
    end
    iStart = 1'b0;
  endtask

  initial begin
    int lat, busyCyc, vcount;
    int unsigned rv;

    vecs[0] = '{16'd0,     "    0", "00000", "  0", 1'b0};
    vecs[1] = '{16'd42,    "   42", "00042", " 42", 1'b0};
    vecs[2] = '{16'd12345, "12345", "12345", "***", 1'b1};
    vecs[3] = '{16'd65535, "65535", "65535", "***", 1'b1};
    vecs[4] = '{16'd1000,  " 1000", "01000", "***", 1'b1};
    vecs[5] = '{16'd999,   "  999", "00999", "999", 1'b0};
    vecs[6] = '{16'd7,     "    7", "00007", "  7", 1'b0};
    vecs[7] = '{16'd100,   "  100", "00100", "100", 1'b0};

    iReset = 1'b1;
    iStart = 1'b0;
    iValue = '0;
    repeat (3) @(negedge clk);
    iReset = 1'b0;
    @(negedge clk);
    checkOutput("reset_chars5", 80'(chars5), 80'("     "));
    checkOutput("reset_chars3", 80'(chars3), 80'("   "));
    checkOutput("reset_busy", 80'(busy5), 80'(0));
    checkOutput("reset_valid", 80'(valid5), 80'(0));
    checkOutput("reset_ovf", 80'(ovf5), 80'(0));

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].value, 0, 16'd0, lat, busyCyc);
      checkOutput("latency", 80'(lat), 80'(18));
      checkOutput("busy_cycles", 80'(busyCyc), 80'(17));
      checkOutput("chars5", 80'(chars5), 80'(vecs[i].exp5));
      checkOutput("charsNb", 80'(charsNb), 80'(vecs[i].expNb));
      checkOutput("chars3", 80'(chars3), 80'(vecs[i].exp3));
      checkOutput("ovf3", 80'(ovf3), 80'(vecs[i].ovf3));
      checkOutput("ovf5", 80'(ovf5), 80'(0));
      @(negedge clk);
      checkOutput("valid_width", 80'(valid5), 80'(0));
      checkOutput("held_chars5", 80'(chars5), 80'(vecs[i].exp5));
    end

    $display("[TB] start while busy");
    applyStimulus(16'd123, 5, 16'd777, lat, busyCyc);
    checkOutput("ignored_latency", 80'(lat), 80'(18));
    checkOutput("ignored_chars5", 80'(chars5), 80'("  123"));
    vcount = 0;
    repeat (25) begin
      @(negedge clk);
      if (valid5) vcount++;
    end
    checkOutput("ignored_no_second_valid", 80'(vcount), 80'(0));

    $display("[TB] start on valid cycle");
    applyStimulus(16'd321, 0, 16'd0, lat, busyCyc);
    checkOutput("b2b_first_chars", 80'(chars5), 80'("  321"));
    iStart = 1'b1;
    iValue = 16'd54321;
    @(negedge clk);
    iStart = 1'b0;
    checkOutput("b2b_busy", 80'(busy5), 80'(1));
    lat = 0;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (valid5) begin
        lat = k;
        break;
      end
    end
    checkOutput("b2b_latency", 80'(lat), 80'(18));
    checkOutput("b2b_chars5", 80'(chars5), 80'("54321"));

    $display("[TB] reset mid-shift");
    @(negedge clk);
    iStart = 1'b1;
    iValue = 16'd500;
    @(negedge clk);
    iStart = 1'b0;
    repeat (5) @(negedge clk);
    iReset = 1'b1;
    @(negedge clk);
    iReset = 1'b0;
    vcount = 0;
    repeat (25) begin
      @(negedge clk);
      if (valid5 || busy5) vcount++;
    end
    checkOutput("abort_no_activity", 80'(vcount), 80'(0));
    checkOutput("abort_chars5", 80'(chars5), 80'("     "));
    checkOutput("abort_chars3", 80'(chars3), 80'("   "));
    checkOutput("abort_ovf", 80'(ovf3), 80'(0));

    $display("[TB] random values");
    for (int i = 0; i < 20; i++) begin
      rv = $urandom_range(0, 65535);
      if (i < 4) rv = $urandom_range(0, 1100);
      applyStimulus(16'(rv), 0, 16'd0, lat, busyCyc);
      checkOutput("rand_latency", 80'(lat), 80'(18));
      checkOutput("rand_chars5", 80'(chars5), modelChars(rv, 5, 1'b1));
      checkOutput("rand_charsNb", 80'(charsNb), modelChars(rv, 5, 1'b0));
      checkOutput("rand_chars3", 80'(chars3), modelChars(rv, 3, 1'b1));
      checkOutput("rand_ovf3", 80'(ovf3), 80'(rv >= 1000));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
